// File: rtl/ysyx_23060203_mem_pkg.sv
// Shared types and memory function codes for the IFU/LSU memory arbiter.
package ysyx_23060203_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // Width/sign codes shared with the EXU load/store unit.
    localparam logic [2:0] FUNC_B  = 3'b000;
    localparam logic [2:0] FUNC_H  = 3'b001;
    localparam logic [2:0] FUNC_W  = 3'b010;
    localparam logic [2:0] FUNC_BU = 3'b100;
    localparam logic [2:0] FUNC_HU = 3'b101;

    localparam logic [2:0] FUNC_WORD = FUNC_W;

endpackage

// File: rtl/ysyx_23060203_mem_watchdog.sv
// Cycle counter that flags a memory response overdue after TIMEOUT_CYC cycles.
// TIMEOUT_CYC = 0 disables the timeout output.
module ysyx_23060203_mem_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned CNT_W       = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_23060203_mem_arbiter.sv
// Shares the single core memory port between the IFU and the LSU, one transaction at a time.
// state | meaning
// IDLE  | grant one requester and latch its request
// ISSUE | present latched request on mem_* until accepted
// WAIT  | await memory response or watchdog timeout
// RESP  | one-cycle response pulse to the owner
module ysyx_23060203_mem_arbiter
    import ysyx_23060203_mem_pkg::*;
#(
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned CNT_W       = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        ifu_req_valid_i,
    output logic        ifu_req_ready_o,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_resp_valid_o,
    output logic [31:0] ifu_rdata_o,
    output logic        ifu_resp_err_o,

    input  logic        lsu_req_valid_i,
    output logic        lsu_req_ready_o,
    input  logic        lsu_wen_i,
    input  logic [2:0]  lsu_func_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_resp_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_resp_err_o,

    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic        mem_wen_o,
    output logic [2:0]  mem_func_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_resp_err_i
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_owner_q, last_owner_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [2:0]  func_q, func_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ifu_rdata_q, ifu_rdata_d;
    logic        ifu_err_q, ifu_err_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        lsu_err_q, lsu_err_d;

    logic        grant_lsu;
    logic        wd_clr;
    logic        wd_timeout;
    logic        rsp_load;
    logic [31:0] rsp_data;
    logic        rsp_err;

    // Round-robin only matters on contention: the previous owner yields.
    assign grant_lsu = lsu_req_valid_i &&
                       ((ARB_MODE == 0) || !ifu_req_valid_i || (last_owner_q == OWN_IFU));

    assign lsu_req_ready_o  = (state_q == ST_IDLE) && grant_lsu;
    assign ifu_req_ready_o  = (state_q == ST_IDLE) && ifu_req_valid_i && !grant_lsu;

    assign mem_req_valid_o  = (state_q == ST_ISSUE);
    assign mem_wen_o        = wen_q;
    assign mem_func_o       = func_q;
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;

    assign ifu_resp_valid_o = (state_q == ST_RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid_o = (state_q == ST_RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata_o      = ifu_rdata_q;
    assign ifu_resp_err_o   = ifu_err_q;
    assign lsu_rdata_o      = lsu_rdata_q;
    assign lsu_resp_err_o   = lsu_err_q;

    ysyx_23060203_mem_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (wd_clr),
        .en_i      (state_q == ST_WAIT),
        .timeout_o (wd_timeout)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        func_d       = func_q;
        wdata_d      = wdata_q;
        ifu_rdata_d  = ifu_rdata_q;
        ifu_err_d    = ifu_err_q;
        lsu_rdata_d  = lsu_rdata_q;
        lsu_err_d    = lsu_err_q;
        wd_clr       = 1'b0;
        rsp_load     = 1'b0;
        rsp_data     = '0;
        rsp_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (lsu_req_ready_o) begin
                    addr_d  = lsu_addr_i;
                    wen_d   = lsu_wen_i;
                    func_d  = lsu_func_i;
                    wdata_d = lsu_wdata_i;
                    owner_d = OWN_LSU;
                    state_d = ST_ISSUE;
                end else if (ifu_req_ready_o) begin
                    addr_d  = ifu_addr_i;
                    wen_d   = 1'b0;
                    func_d  = FUNC_WORD;
                    wdata_d = '0;
                    owner_d = OWN_IFU;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready_i) begin
                    wd_clr  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real response takes precedence over a simultaneous timeout.
                if (mem_resp_valid_i) begin
                    rsp_load = 1'b1;
                    rsp_data = mem_rdata_i;
                    rsp_err  = mem_resp_err_i;
                end else if (wd_timeout) begin
                    rsp_load = 1'b1;
                    rsp_err  = 1'b1;
                end
            end
            ST_RESP: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rsp_load) begin
            state_d = ST_RESP;
            if (owner_q == OWN_LSU) begin
                lsu_rdata_d = rsp_data;
                lsu_err_d   = rsp_err;
            end else begin
                ifu_rdata_d = rsp_data;
                ifu_err_d   = rsp_err;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            last_owner_q <= OWN_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            func_q       <= '0;
            wdata_q      <= '0;
            ifu_rdata_q  <= '0;
            ifu_err_q    <= 1'b0;
            lsu_rdata_q  <= '0;
            lsu_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            func_q       <= func_d;
            wdata_q      <= wdata_d;
            ifu_rdata_q  <= ifu_rdata_d;
            ifu_err_q    <= ifu_err_d;
            lsu_rdata_q  <= lsu_rdata_d;
            lsu_err_q    <= lsu_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_mem_arbiter.sv
// Self-checking bench: fixed-priority (d0) and round-robin (d1) arbiters, both with an 8-cycle watchdog.
module tb_ysyx_23060203_mem_arbiter;
    import ysyx_23060203_mem_pkg::*;

    typedef struct packed {
        logic        own;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_wen = 1'b0;
    logic [2:0]  lsu_func = '0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp_err = 1'b0;

    logic        ifu_rdy_w [2];
    logic        lsu_rdy_w [2];
    logic        ifu_rv_w [2];
    logic        lsu_rv_w [2];
    logic [31:0] ifu_rdata_w [2];
    logic [31:0] lsu_rdata_w [2];
    logic        ifu_err_w [2];
    logic        lsu_err_w [2];
    logic        mreq_v_w [2];
    logic        mwen_w [2];
    logic [2:0]  mfunc_w [2];
    logic [31:0] maddr_w [2];
    logic [31:0] mwdata_w [2];

    logic sel = 1'b0;
    logic        s_ifu_rdy, s_lsu_rdy, s_ifu_rv, s_lsu_rv, s_ifu_err, s_lsu_err, s_mreq_v, s_mwen;
    logic [31:0] s_ifu_rdata, s_lsu_rdata, s_maddr, s_mwdata;
    logic [2:0]  s_mfunc;

    assign s_ifu_rdy   = ifu_rdy_w[sel];
    assign s_lsu_rdy   = lsu_rdy_w[sel];
    assign s_ifu_rv    = ifu_rv_w[sel];
    assign s_lsu_rv    = lsu_rv_w[sel];
    assign s_ifu_rdata = ifu_rdata_w[sel];
    assign s_lsu_rdata = lsu_rdata_w[sel];
    assign s_ifu_err   = ifu_err_w[sel];
    assign s_lsu_err   = lsu_err_w[sel];
    assign s_mreq_v    = mreq_v_w[sel];
    assign s_mwen      = mwen_w[sel];
    assign s_mfunc     = mfunc_w[sel];
    assign s_maddr     = maddr_w[sel];
    assign s_mwdata    = mwdata_w[sel];

    ysyx_23060203_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYC(8), .CNT_W(10)) d0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_rdy_w[0]), .ifu_addr_i(ifu_addr),
        .ifu_resp_valid_o(ifu_rv_w[0]), .ifu_rdata_o(ifu_rdata_w[0]), .ifu_resp_err_o(ifu_err_w[0]),
        .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_rdy_w[0]), .lsu_wen_i(lsu_wen),
        .lsu_func_i(lsu_func), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_resp_valid_o(lsu_rv_w[0]), .lsu_rdata_o(lsu_rdata_w[0]), .lsu_resp_err_o(lsu_err_w[0]),
        .mem_req_valid_o(mreq_v_w[0]), .mem_req_ready_i(mem_req_ready), .mem_wen_o(mwen_w[0]),
        .mem_func_o(mfunc_w[0]), .mem_addr_o(maddr_w[0]), .mem_wdata_o(mwdata_w[0]),
        .mem_resp_valid_i(mem_resp_valid), .mem_rdata_i(mem_rdata), .mem_resp_err_i(mem_resp_err)
    );

    ysyx_23060203_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYC(8), .CNT_W(4)) d1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ifu_req_valid_i(ifu_req_valid), .ifu_req_ready_o(ifu_rdy_w[1]), .ifu_addr_i(ifu_addr),
        .ifu_resp_valid_o(ifu_rv_w[1]), .ifu_rdata_o(ifu_rdata_w[1]), .ifu_resp_err_o(ifu_err_w[1]),
        .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_rdy_w[1]), .lsu_wen_i(lsu_wen),
        .lsu_func_i(lsu_func), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_resp_valid_o(lsu_rv_w[1]), .lsu_rdata_o(lsu_rdata_w[1]), .lsu_resp_err_o(lsu_err_w[1]),
        .mem_req_valid_o(mreq_v_w[1]), .mem_req_ready_i(mem_req_ready), .mem_wen_o(mwen_w[1]),
        .mem_func_o(mfunc_w[1]), .mem_addr_o(maddr_w[1]), .mem_wdata_o(mwdata_w[1]),
        .mem_resp_valid_i(mem_resp_valid), .mem_rdata_i(mem_rdata), .mem_resp_err_i(mem_resp_err)
    );

    always #5 clk_i = ~clk_i;

    int   n_chk = 0;
    int   n_pass = 0;
    int   ifu_pulses = 0;
    int   lsu_pulses = 0;
    exp_t sb_q[$];

    // Pulse counters for the selected instance; only this process writes them.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (s_ifu_rv) ifu_pulses <= ifu_pulses + 1;
            if (s_lsu_rv) lsu_pulses <= lsu_pulses + 1;
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_func = '0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
        rst_ni = 1'b0;
        repeat (2) cyc();
        rst_ni = 1'b1;
        cyc();
    endtask

    // Memory slave: waits (bounded) for an issue, captures it, accepts after lag, responds next cycle.
    // Returns in the cycle the arbiter should pulse its response.
    task automatic serve(input logic [31:0] rd, input logic er, input int lag,
                         output logic [68:0] cap);
        int n;
        n = 0;
        while (s_mreq_v !== 1'b1 && n < 16) begin
            cyc();
            n++;
        end
        cap = {s_mreq_v, s_mwen, s_mfunc, s_maddr, s_mwdata};
        repeat (lag) cyc();
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = rd; mem_resp_err = er;
        cyc();
        mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        rst_ni = 1'b0;
        #1;
        n_chk++;
        if ({s_ifu_rdy, s_lsu_rdy, s_mreq_v, s_ifu_rv, s_lsu_rv} !== 5'b0)
            $display("FAIL reset_valids: got %b want 00000", {s_ifu_rdy, s_lsu_rdy, s_mreq_v, s_ifu_rv, s_lsu_rv});
        else n_pass++;
        n_chk++;
        if ({s_mwen, s_mfunc, s_maddr, s_mwdata} !== 68'h0)
            $display("FAIL reset_mem_fields: got %h want 0", {s_mwen, s_mfunc, s_maddr, s_mwdata});
        else n_pass++;
        n_chk++;
        if ({s_ifu_rdata, s_ifu_err, s_lsu_rdata, s_lsu_err} !== 66'h0)
            $display("FAIL reset_resp_data: got %h want 0", {s_ifu_rdata, s_ifu_err, s_lsu_rdata, s_lsu_err});
        else n_pass++;
        rst_ni = 1'b1;
        cyc();
        ifu_req_valid = 1'b1;
        #1;
        n_chk++;
        if ({s_ifu_rdy, s_lsu_rdy} !== 2'b10)
            $display("FAIL reset_idle_grant: got %b want 10", {s_ifu_rdy, s_lsu_rdy});
        else n_pass++;
        ifu_req_valid = 1'b0;
        cyc();
    endtask

    task automatic test_ifu_fetch();
        logic [68:0] cap;
        exp_t e;
        int   ip, lp;
        sel = 1'b0;
        do_reset();
        ip = ifu_pulses; lp = lsu_pulses;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        n_chk++;
        if ({s_ifu_rdy, s_lsu_rdy} !== 2'b10)
            $display("FAIL fetch_ready: got %b want 10", {s_ifu_rdy, s_lsu_rdy});
        else n_pass++;
        sb_q.push_back(exp_t'{own: 1'b0, rdata: 32'h0000_0413, err: 1'b0});
        cyc();
        ifu_req_valid = 1'b0;
        serve(32'h0000_0413, 1'b0, 0, cap);
        n_chk++;
        if (cap[68:32] !== {1'b1, 1'b0, FUNC_W, 32'h8000_0000})
            $display("FAIL fetch_issue: got %h want %h", cap[68:32], {1'b1, 1'b0, FUNC_W, 32'h8000_0000});
        else n_pass++;
        e = sb_q.pop_front();
        n_chk++;
        if ({s_ifu_rv, s_lsu_rv, s_ifu_rdata, s_ifu_err} !== {1'b1, 1'b0, e.rdata, e.err})
            $display("FAIL fetch_resp: got v=%b/%b rdata=%h err=%b want 1/0 %h %b",
                     s_ifu_rv, s_lsu_rv, s_ifu_rdata, s_ifu_err, e.rdata, e.err);
        else n_pass++;
        cyc();
        n_chk++;
        if ({s_ifu_rv, s_ifu_rdata} !== {1'b0, 32'h0000_0413})
            $display("FAIL fetch_hold: got v=%b rdata=%h want 0 00000413", s_ifu_rv, s_ifu_rdata);
        else n_pass++;
        n_chk++;
        if ({ifu_pulses - ip, lsu_pulses - lp} !== {32'd1, 32'd0})
            $display("FAIL fetch_pulses: got ifu=%0d lsu=%0d want 1 0", ifu_pulses - ip, lsu_pulses - lp);
        else n_pass++;
    endtask

    task automatic test_arb_fixed();
        logic [68:0] cap;
        exp_t e;
        sel = 1'b0;
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b0; lsu_func = FUNC_W;
        #1;
        n_chk++;
        if ({s_lsu_rdy, s_ifu_rdy} !== 2'b10)
            $display("FAIL fixed_first_grant: got lsu/ifu=%b want 10", {s_lsu_rdy, s_ifu_rdy});
        else n_pass++;
        sb_q.push_back(exp_t'{own: 1'b1, rdata: 32'h1111_1111, err: 1'b0});
        cyc();
        lsu_req_valid = 1'b0;
        serve(32'h1111_1111, 1'b0, 0, cap);
        n_chk++;
        if (cap[68:32] !== {1'b1, 1'b0, FUNC_W, 32'h8000_1000})
            $display("FAIL fixed_lsu_issue: got %h want %h", cap[68:32], {1'b1, 1'b0, FUNC_W, 32'h8000_1000});
        else n_pass++;
        e = sb_q.pop_front();
        n_chk++;
        if ({s_lsu_rv, s_ifu_rv, s_lsu_rdata, s_lsu_err, s_ifu_rdy} !== {1'b1, 1'b0, e.rdata, e.err, 1'b0})
            $display("FAIL fixed_lsu_resp: got v=%b/%b rdata=%h err=%b ifu_rdy=%b want 1/0 %h %b 0",
                     s_lsu_rv, s_ifu_rv, s_lsu_rdata, s_lsu_err, s_ifu_rdy, e.rdata, e.err);
        else n_pass++;
        cyc();
        n_chk++;
        if ({s_ifu_rdy, s_lsu_rdy} !== 2'b10)
            $display("FAIL fixed_ifu_after: got %b want 10", {s_ifu_rdy, s_lsu_rdy});
        else n_pass++;
        sb_q.push_back(exp_t'{own: 1'b0, rdata: 32'h2222_2222, err: 1'b0});
        cyc();
        ifu_req_valid = 1'b0;
        serve(32'h2222_2222, 1'b0, 0, cap);
        n_chk++;
        if (cap[68:32] !== {1'b1, 1'b0, FUNC_W, 32'h8000_0000})
            $display("FAIL fixed_ifu_issue: got %h want %h", cap[68:32], {1'b1, 1'b0, FUNC_W, 32'h8000_0000});
        else n_pass++;
        e = sb_q.pop_front();
        n_chk++;
        if ({s_ifu_rv, s_lsu_rv, s_ifu_rdata, s_ifu_err} !== {1'b1, 1'b0, e.rdata, e.err})
            $display("FAIL fixed_ifu_resp: got v=%b/%b rdata=%h err=%b want 1/0 %h %b",
                     s_ifu_rv, s_lsu_rv, s_ifu_rdata, s_ifu_err, e.rdata, e.err);
        else n_pass++;
        cyc();
    endtask

    task automatic test_arb_rr();
        logic [68:0] cap;
        logic        own_exp;
        logic [31:0] addr_exp;
        exp_t e;
        sel = 1'b1;
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; lsu_func = FUNC_W;
        for (int i = 0; i < 3; i++) begin
            own_exp  = (i != 1);
            addr_exp = own_exp ? 32'h8000_3000 : 32'h8000_0100;
            #1;
            n_chk++;
            if ({s_lsu_rdy, s_ifu_rdy} !== {own_exp, ~own_exp})
                $display("FAIL rr_grant_%0d: got lsu/ifu=%b want %b", i, {s_lsu_rdy, s_ifu_rdy}, {own_exp, ~own_exp});
            else n_pass++;
            sb_q.push_back(exp_t'{own: own_exp, rdata: 32'hA000_0000 + 32'(i), err: 1'b0});
            cyc();
            serve(32'hA000_0000 + 32'(i), 1'b0, 0, cap);
            n_chk++;
            if (cap[68:32] !== {1'b1, 1'b0, FUNC_W, addr_exp})
                $display("FAIL rr_issue_%0d: got %h want %h", i, cap[68:32], {1'b1, 1'b0, FUNC_W, addr_exp});
            else n_pass++;
            e = sb_q.pop_front();
            n_chk++;
            if (e.own ? ({s_lsu_rv, s_ifu_rv, s_lsu_rdata, s_lsu_err} !== {1'b1, 1'b0, e.rdata, e.err})
                      : ({s_ifu_rv, s_lsu_rv, s_ifu_rdata, s_ifu_err} !== {1'b1, 1'b0, e.rdata, e.err}))
                $display("FAIL rr_resp_%0d: got lsu_v=%b ifu_v=%b lsu=%h ifu=%h want own=%b %h",
                         i, s_lsu_rv, s_ifu_rv, s_lsu_rdata, s_ifu_rdata, e.own, e.rdata);
            else n_pass++;
            cyc();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        cyc();
    endtask

    task automatic test_store_stall();
        logic [72:0] want;
        exp_t e;
        int   lp;
        sel = 1'b0;
        do_reset();
        lp = lsu_pulses;
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_func = FUNC_W;
        lsu_addr = 32'h8000_2004; lsu_wdata = 32'hDEAD_BEEF;
        sb_q.push_back(exp_t'{own: 1'b1, rdata: 32'h0000_55AA, err: 1'b0});
        cyc();
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wen = 1'b0;
        want = {1'b1, 1'b1, 4'b0, FUNC_W, 32'h8000_2004, 32'hDEAD_BEEF};
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({s_mreq_v, s_mwen, 4'b0, s_mfunc, s_maddr, s_mwdata} !== want)
                $display("FAIL store_stall_%0d: got v=%b wen=%b func=%b addr=%h wdata=%h", i,
                         s_mreq_v, s_mwen, s_mfunc, s_maddr, s_mwdata);
            else n_pass++;
            cyc();
        end
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_55AA;
        cyc();
        mem_resp_valid = 1'b0; mem_rdata = '0;
        e = sb_q.pop_front();
        n_chk++;
        if ({s_lsu_rv, s_ifu_rv, s_lsu_rdata, s_lsu_err} !== {1'b1, 1'b0, e.rdata, e.err})
            $display("FAIL store_resp: got v=%b/%b rdata=%h err=%b want 1/0 %h %b",
                     s_lsu_rv, s_ifu_rv, s_lsu_rdata, s_lsu_err, e.rdata, e.err);
        else n_pass++;
        repeat (2) cyc();
        n_chk++;
        if (lsu_pulses - lp !== 1)
            $display("FAIL store_pulse_count: got %0d want 1", lsu_pulses - lp);
        else n_pass++;
    endtask

    task automatic test_timeout();
        logic [68:0] cap;
        exp_t e;
        sel = 1'b0;
        do_reset();
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_func = FUNC_BU; lsu_addr = 32'h8000_4000;
        sb_q.push_back(exp_t'{own: 1'b1, rdata: 32'hCAFE_F00D, err: 1'b0});
        cyc();
        lsu_req_valid = 1'b0;
        serve(32'hCAFE_F00D, 1'b0, 0, cap);
        e = sb_q.pop_front();
        n_chk++;
        if ({s_lsu_rv, s_lsu_rdata, s_lsu_err, cap[67:64]} !== {1'b1, e.rdata, e.err, 1'b0, FUNC_BU})
            $display("FAIL tmo_pre_load: got v=%b rdata=%h err=%b wen/func=%b", s_lsu_rv, s_lsu_rdata, s_lsu_err, cap[67:64]);
        else n_pass++;
        cyc();
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_4004; lsu_func = FUNC_W;
        sb_q.push_back(exp_t'{own: 1'b1, rdata: 32'h0, err: 1'b1});
        cyc();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_chk++;
            if (s_lsu_rv !== 1'b0)
                $display("FAIL tmo_early_%0d: got lsu_resp_valid=%b want 0", k, s_lsu_rv);
            else n_pass++;
            cyc();
        end
        e = sb_q.pop_front();
        n_chk++;
        if ({s_lsu_rv, s_lsu_rdata, s_lsu_err} !== {1'b1, e.rdata, e.err})
            $display("FAIL tmo_resp: got v=%b rdata=%h err=%b want 1 %h %b", s_lsu_rv, s_lsu_rdata, s_lsu_err, e.rdata, e.err);
        else n_pass++;
        cyc();
        lsu_req_valid = 1'b1;
        #1;
        n_chk++;
        if (s_lsu_rdy !== 1'b1)
            $display("FAIL tmo_back_idle: got lsu_req_ready=%b want 1", s_lsu_rdy);
        else n_pass++;
        lsu_req_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_wait();
        logic [68:0] cap;
        exp_t e;
        int   ip;
        sel = 1'b0;
        do_reset();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
        sb_q.push_back(exp_t'{own: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
        cyc();
        ifu_req_valid = 1'b0;
        serve(32'h1234_5678, 1'b0, 0, cap);
        e = sb_q.pop_front();
        n_chk++;
        if ({s_ifu_rv, s_ifu_rdata} !== {1'b1, e.rdata})
            $display("FAIL rst_pre_fetch: got v=%b rdata=%h want 1 %h", s_ifu_rv, s_ifu_rdata, e.rdata);
        else n_pass++;
        cyc();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
        cyc();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        cyc();
        mem_req_ready = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        n_chk++;
        if ({s_ifu_rdy, s_lsu_rdy, s_mreq_v, s_ifu_rv, s_lsu_rv, s_maddr, s_ifu_rdata} !== 69'h0)
            $display("FAIL rst_async_clear: got ctrl=%b addr=%h ifu_rdata=%h want 0",
                     {s_ifu_rdy, s_lsu_rdy, s_mreq_v, s_ifu_rv, s_lsu_rv}, s_maddr, s_ifu_rdata);
        else n_pass++;
        repeat (2) cyc();
        rst_ni = 1'b1;
        cyc();
        ip = ifu_pulses;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0BAD; mem_resp_err = 1'b1;
        cyc();
        mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
        repeat (2) cyc();
        n_chk++;
        if ({ifu_pulses - ip, 31'b0, s_ifu_rv} !== 64'h0)
            $display("FAIL rst_stale_ignored: got pulses=%0d resp_valid=%b want 0 0", ifu_pulses - ip, s_ifu_rv);
        else n_pass++;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0204;
        #1;
        n_chk++;
        if (s_ifu_rdy !== 1'b1)
            $display("FAIL rst_new_grant: got ifu_req_ready=%b want 1", s_ifu_rdy);
        else n_pass++;
        sb_q.push_back(exp_t'{own: 1'b0, rdata: 32'h0010_0073, err: 1'b0});
        cyc();
        ifu_req_valid = 1'b0;
        serve(32'h0010_0073, 1'b0, 0, cap);
        e = sb_q.pop_front();
        n_chk++;
        if ({s_ifu_rv, s_ifu_rdata, s_ifu_err, cap[63:32]} !== {1'b1, e.rdata, e.err, 32'h8000_0204})
            $display("FAIL rst_new_fetch: got v=%b rdata=%h err=%b addr=%h want 1 %h %b 80000204",
                     s_ifu_rv, s_ifu_rdata, s_ifu_err, cap[63:32], e.rdata, e.err);
        else n_pass++;
        repeat (2) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ifu_fetch();
        test_arb_fixed();
        test_arb_rr();
        test_store_stall();
        test_timeout();
        test_reset_mid_wait();
        n_chk++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_mem_arbiter.md
Name: ysyx_23060203_mem_arbiter

Overview:
- Shares the single core memory port between two requesters: the IFU (instruction fetch, read-only) and the LSU (the EXU's load/store interface).
- Accepts one request at a time, latches it, and issues it to the memory port with a valid/ready handshake.
- Waits for the response and returns it to the granted requester as a one-cycle pulse.
- A watchdog converts a hung memory into an error response.

Parameters:
- ARB_MODE, 0: arbitration policy. 0 = fixed LSU priority; 1 = round-robin.
- TIMEOUT_CYC, 1023: maximum cycles spent in WAIT before a forced error response. 0 disables the watchdog.
- CNT_W, 10: watchdog counter width. Must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted
- ifu_addr  in  32  fetch address; func is fixed to word read
- ifu_resp_valid  out  1  fetch response pulse
- ifu_rdata  out  32  fetched instruction
- ifu_resp_err  out  1  fetch error
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted
- lsu_wen  in  1  1 = store, 0 = load
- lsu_func  in  3  width/sign code, same encoding as the EXU mem func
- lsu_addr  in  32  access address
- lsu_wdata  in  32  store data
- lsu_resp_valid  out  1  load/store response pulse
- lsu_rdata  out  32  load data
- lsu_resp_err  out  1  load/store error
- mem_req_valid  out  1  issued request
- mem_req_ready  in  1  memory accepted the request
- mem_wen  out  1  write enable
- mem_func  out  3  width/sign code
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_resp_valid  in  1  memory response
- mem_rdata  in  32  response data
- mem_resp_err  in  1  memory error

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state = IDLE; all valid/ready outputs = 0; all data outputs = 0; owner = IFU; last_owner = IFU; watchdog counter = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant is computed combinationally.
  - ARB_MODE=0: LSU wins if lsu_req_valid, else IFU.
  - ARB_MODE=1: when both requesters are valid, the one that is not last_owner wins; a single valid requester always wins.
  - The granted requester's X_req_ready = 1; the other requester's ready = 0.
  - Ready is 0 in every state other than IDLE.
  - On handshake: latch addr, wen, func and wdata into internal registers (IFU: wen = 0, func = word), set owner, go to ISSUE.
- ISSUE:
  - mem_req_valid = 1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready: go to WAIT and clear the watchdog counter.
- WAIT:
  - Counter increments each cycle.
  - On mem_resp_valid: latch mem_rdata and mem_resp_err, go to RESP.
  - If TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC - 1 without a response: latch rdata = 0, err = 1, go to RESP.
  - If a response and the timeout occur in the same cycle, the real response wins.
- RESP:
  - owner_resp_valid = 1 for exactly one cycle with the latched rdata/err; last_owner <= owner; go to IDLE.
  - The non-owner's resp_valid is always 0.
- Latency:
  - Requester handshake at cycle 0 → mem_req_valid at cycle 1.
  - Memory accepts at cycle 1 and responds at cycle 2 → owner resp_valid at cycle 3.
  - Next grant possible at cycle 4 (IDLE).
- Protocol rules:
  - mem_resp_valid outside WAIT is ignored; memory must respond at least one cycle after accept.
  - Response payload outputs hold their last value between pulses.
  - Store responses forward mem_rdata unchanged; the LSU ignores it.
- Reset mid-transaction: immediate return to IDLE with all outputs cleared. An in-flight memory transaction is abandoned, and the memory slave is reset by the same rst_n.
- Only one outstanding transaction exists at any time.

Decomposition:
- Package ysyx_23060203_mem_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - owner enum (OWN_IFU/OWN_LSU)
  - the 3-bit mem func codes shared with the EXU (word-read constant used for IFU)
- Sub-module ysyx_23060203_mem_watchdog: counter with clear/enable inputs and a timeout output, parameterised by TIMEOUT_CYC and CNT_W.

Test Plan:
- IFU only, addr 0x80000000, memory ready immediately, responds 1 cycle later with 0x00000413 → ifu_resp_valid pulses at cycle 3 with rdata 0x00000413, err 0; lsu_resp_valid stays 0.
- Both requesters valid in the same cycle, ARB_MODE=0: LSU load at 0x80001000 is granted first; IFU is granted in the IDLE cycle after the LSU response pulse. ARB_MODE=1 with both valid repeatedly → grants alternate LSU, IFU, LSU.
- LSU store (wen=1, func=word, addr 0x80002004, wdata 0xDEADBEEF), mem_req_ready low for 3 cycles → mem_* fields stay stable for all 3 cycles; lsu_resp_valid pulses once after the response.
- TIMEOUT_CYC=8, memory never responds → lsu_resp_valid with err=1 and rdata=0 exactly 8 cycles after entering WAIT; the arbiter then returns to IDLE.
- rst_n asserted during WAIT → all outputs are 0 immediately (asynchronously); after release, a new IFU request completes normally and a stale mem_resp_valid is ignored.
